// File: rtl/wb_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wb_load_ctrl
// Purpose  : Writeback / load-store controller for a single-issue core.
//            Non-memory instructions retire combinationally in the cycle they
//            are presented. Aligned loads and stores are latched and run a
//            request/grant/rvalid handshake on the data-memory port while
//            fetch is stalled, then retire in a one-cycle DONE state.
//            Misaligned accesses retire immediately with a misalign pulse
//            and never reach memory.
// Ports    :
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_*/mem_*/size_i  instruction-side operands (see port list)
//   dmem_*                data-memory request/response port
//   rf_*                  register-file write port
//   pc_we_o, pc_next_o    program-counter update
//   stall_o               hold fetch and instruction inputs
//   misalign_o            one-cycle misaligned-access pulse
// Revision : 1.0 - initial release
// ============================================================================
module wb_load_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    // instruction side
    input  logic        instr_valid_i,
    input  logic        mem_op_i,
    input  logic        mem_we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    input  logic        reg_write_i,
    input  logic [31:0] alu_data_i,
    input  logic        setJalr_i,
    input  logic [31:0] pc_add4_i,
    input  logic        branch_taken_i,
    input  logic [31:0] pc_branch_i,
    // data memory
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    // writeback / fetch
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        pc_we_o,
    output logic [31:0] pc_next_o,
    output logic        stall_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic        is_load_q,   is_load_d;
    logic [1:0]  size_q,      size_d;
    logic        unsigned_q,  unsigned_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [4:0]  rd_q,        rd_d;
    logic [31:0] pc_next_q,   pc_next_d;
    logic [31:0] rdata_q,     rdata_d;

    // Combinational output values before reset gating
    logic        w_dmem_req;
    logic        w_dmem_we;
    logic [31:0] w_dmem_addr;
    logic [31:0] w_dmem_wdata;
    logic [3:0]  w_dmem_be;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;
    logic        w_pc_we;
    logic [31:0] w_pc_next;
    logic        w_stall;
    logic        w_misalign;

    logic        w_addr_misaligned;
    logic [31:0] w_pc_next_live;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_lanes;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;

    // ------------------------------------------------------------------
    // Decode of the live instruction
    // ------------------------------------------------------------------
    // Size 2'b11 is treated as a word everywhere (size[1] set).
    assign w_addr_misaligned = ((size_i == 2'b01) && addr_i[0]) ||
                               (size_i[1] && (addr_i[1:0] != 2'b00));
    assign w_pc_next_live    = branch_taken_i ? pc_branch_i : pc_add4_i;

    // ------------------------------------------------------------------
    // Store lane formatting from the latched access
    // ------------------------------------------------------------------
    always_comb begin
        w_be          = 4'b1111;
        w_wdata_lanes = wdata_q;
        case (size_q)
            2'b00: begin
                w_be          = 4'b0001 << addr_q[1:0];
                w_wdata_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                w_be          = 4'b0011 << addr_q[1:0];
                w_wdata_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                w_be          = 4'b1111;
                w_wdata_lanes = wdata_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane selection and extension from the captured read data
    // ------------------------------------------------------------------
    always_comb begin
        w_ld_byte = rdata_q[7:0];
        case (addr_q[1:0])
            2'b00:   w_ld_byte = rdata_q[7:0];
            2'b01:   w_ld_byte = rdata_q[15:8];
            2'b10:   w_ld_byte = rdata_q[23:16];
            default: w_ld_byte = rdata_q[31:24];
        endcase
        w_ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q)
            2'b00:   w_ld_data = unsigned_q ? {24'h0, w_ld_byte}
                                            : {{24{w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_ld_data = unsigned_q ? {16'h0, w_ld_half}
                                            : {{16{w_ld_half[15]}}, w_ld_half};
            default: w_ld_data = rdata_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        is_load_d    = is_load_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        pc_next_d    = pc_next_q;
        rdata_d      = rdata_q;

        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_dmem_addr  = 32'h0;
        w_dmem_wdata = 32'h0;
        w_dmem_be    = 4'b0000;
        w_rf_we      = 1'b0;
        w_rf_waddr   = rd_q;
        w_rf_wdata   = 32'h0;
        w_pc_we      = 1'b0;
        w_pc_next    = pc_next_q;
        w_stall      = 1'b0;
        w_misalign   = 1'b0;

        case (state_q)
            IDLE: begin
                w_pc_next  = w_pc_next_live;
                w_rf_waddr = rd_i;
                w_rf_wdata = setJalr_i ? pc_add4_i : alu_data_i;
                if (instr_valid_i) begin
                    if (!mem_op_i) begin
                        w_pc_we = 1'b1;
                        w_rf_we = reg_write_i && (rd_i != 5'd0);
                    end else if (w_addr_misaligned) begin
                        // Retire without touching memory or the register file
                        w_misalign = 1'b1;
                        w_pc_we    = 1'b1;
                    end else begin
                        w_stall    = 1'b1;
                        state_d    = REQ;
                        is_load_d  = !mem_we_i;
                        size_d     = size_i;
                        unsigned_d = unsigned_i;
                        addr_d     = addr_i;
                        wdata_d    = wdata_i;
                        rd_d       = rd_i;
                        pc_next_d  = w_pc_next_live;
                    end
                end
            end
            REQ: begin
                w_stall      = 1'b1;
                w_dmem_req   = 1'b1;
                w_dmem_we    = !is_load_q;
                w_dmem_addr  = {addr_q[31:2], 2'b00};
                w_dmem_wdata = w_wdata_lanes;
                w_dmem_be    = w_be;
                if (dmem_gnt_i) begin
                    state_d = is_load_q ? WAIT : DONE;
                end
            end
            WAIT: begin
                w_stall = 1'b1;
                if (dmem_rvalid_i) begin
                    rdata_d = dmem_rdata_i;
                    state_d = DONE;
                end
            end
            DONE: begin
                w_pc_we    = 1'b1;
                w_rf_we    = is_load_q && (rd_q != 5'd0);
                w_rf_waddr = rd_q;
                w_rf_wdata = w_ld_data;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and latched-operand registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            is_load_q  <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rd_q       <= 5'd0;
            pc_next_q  <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            pc_next_q  <= pc_next_d;
            rdata_q    <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs are forced low while reset is asserted, even though the
    // IDLE path is combinational from the live instruction inputs.
    // ------------------------------------------------------------------
    assign dmem_req_o   = rst_n & w_dmem_req;
    assign dmem_we_o    = rst_n & w_dmem_we;
    assign dmem_addr_o  = rst_n ? w_dmem_addr  : 32'h0;
    assign dmem_wdata_o = rst_n ? w_dmem_wdata : 32'h0;
    assign dmem_be_o    = rst_n ? w_dmem_be    : 4'b0000;
    assign rf_we_o      = rst_n & w_rf_we;
    assign rf_waddr_o   = rst_n ? w_rf_waddr   : 5'd0;
    assign rf_wdata_o   = rst_n ? w_rf_wdata   : 32'h0;
    assign pc_we_o      = rst_n & w_pc_we;
    assign pc_next_o    = rst_n ? w_pc_next    : 32'h0;
    assign stall_o      = rst_n & w_stall;
    assign misalign_o   = rst_n & w_misalign;

endmodule
`default_nettype wire

// File: tb/tb_wb_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_load_ctrl
// Purpose  : Self-checking bench for wb_load_ctrl: a vector table of
//            single-cycle IDLE behaviour plus hand-written load, store and
//            reset-abort sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid_i, mem_op_i, mem_we_i, unsigned_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i, alu_data_i, pc_add4_i, pc_branch_i;
    logic [4:0]  rd_i;
    logic        reg_write_i, setJalr_i, branch_taken_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        pc_we_o;
    logic [31:0] pc_next_o;
    logic        stall_o, misalign_o;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_load_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid_i (instr_valid_i),
        .mem_op_i      (mem_op_i),
        .mem_we_i      (mem_we_i),
        .size_i        (size_i),
        .unsigned_i    (unsigned_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rd_i          (rd_i),
        .reg_write_i   (reg_write_i),
        .alu_data_i    (alu_data_i),
        .setJalr_i     (setJalr_i),
        .pc_add4_i     (pc_add4_i),
        .branch_taken_i(branch_taken_i),
        .pc_branch_i   (pc_branch_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .pc_we_o       (pc_we_o),
        .pc_next_o     (pc_next_o),
        .stall_o       (stall_o),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        mem_op;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic        reg_write;
        logic [31:0] alu;
        logic        jalr;
        logic [31:0] pc4;
        logic        br;
        logic [31:0] pcb;
        logic        e_rfwe;
        logic [31:0] e_wdata;
        logic        e_pcwe;
        logic [31:0] e_pcnext;
        logic        e_stall;
        logic        e_mis;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    // and outputs are sampled 2 time units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        instr_valid_i  = 1'b0;
        mem_op_i       = 1'b0;
        mem_we_i       = 1'b0;
        size_i         = 2'b00;
        unsigned_i     = 1'b0;
        addr_i         = 32'h0;
        wdata_i        = 32'h0;
        rd_i           = 5'd0;
        reg_write_i    = 1'b0;
        alu_data_i     = 32'h0;
        setJalr_i      = 1'b0;
        pc_add4_i      = 32'h0;
        branch_taken_i = 1'b0;
        pc_branch_i    = 32'h0;
        dmem_gnt_i     = 1'b0;
        dmem_rvalid_i  = 1'b0;
        dmem_rdata_i   = 32'h0;
    endtask

    // Load sequence. The instruction is offered for one cycle with a taken
    // branch, then the live inputs are cleared so the DONE cycle can only be
    // correct if the operands and next PC were latched.
    task automatic do_load(input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [4:0] rd,
                           input logic [31:0] rdata, input int gnt_wait,
                           input logic [31:0] exp_data);
        step();
        clr_inputs();
        instr_valid_i  = 1'b1;
        mem_op_i       = 1'b1;
        mem_we_i       = 1'b0;
        size_i         = size;
        unsigned_i     = uns;
        addr_i         = addr;
        rd_i           = rd;
        reg_write_i    = 1'b1;
        pc_add4_i      = 32'h1000;
        branch_taken_i = 1'b1;
        pc_branch_i    = 32'h2000;
        #2;
        chk("ld_c0_stall", 32'(stall_o), 32'd1);
        chk("ld_c0_pcwe",  32'(pc_we_o), 32'd0);
        chk("ld_c0_req",   32'(dmem_req_o), 32'd0);
        step();
        clr_inputs();
        for (int i = 0; i <= gnt_wait; i++) begin
            dmem_gnt_i = (i == gnt_wait);
            #2;
            chk("ld_req",   32'(dmem_req_o), 32'd1);
            chk("ld_we",    32'(dmem_we_o), 32'd0);
            chk("ld_addr",  dmem_addr_o, {addr[31:2], 2'b00});
            chk("ld_stall", 32'(stall_o), 32'd1);
            step();
        end
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        #2;
        chk("ld_wait_stall", 32'(stall_o), 32'd1);
        chk("ld_wait_req",   32'(dmem_req_o), 32'd0);
        chk("ld_wait_rfwe",  32'(rf_we_o), 32'd0);
        step();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        #2;
        chk("ld_done_stall",  32'(stall_o), 32'd0);
        chk("ld_done_pcwe",   32'(pc_we_o), 32'd1);
        chk("ld_done_pcnext", pc_next_o, 32'h2000);
        chk("ld_done_rfwe",   32'(rf_we_o), (rd != 5'd0) ? 32'd1 : 32'd0);
        if (rd != 5'd0) begin
            chk("ld_done_waddr", 32'(rf_waddr_o), 32'(rd));
            chk("ld_done_wdata", rf_wdata_o, exp_data);
        end
        step();
        #2;
        chk("ld_after_pcwe", 32'(pc_we_o), 32'd0);
        chk("ld_after_rfwe", 32'(rf_we_o), 32'd0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wdata, input int gnt_wait,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        step();
        clr_inputs();
        instr_valid_i = 1'b1;
        mem_op_i      = 1'b1;
        mem_we_i      = 1'b1;
        size_i        = size;
        addr_i        = addr;
        wdata_i       = wdata;
        rd_i          = 5'd5;
        reg_write_i   = 1'b1;
        pc_add4_i     = 32'h3004;
        #2;
        chk("st_c0_stall", 32'(stall_o), 32'd1);
        chk("st_c0_rfwe",  32'(rf_we_o), 32'd0);
        step();
        clr_inputs();
        for (int i = 0; i <= gnt_wait; i++) begin
            dmem_gnt_i = (i == gnt_wait);
            #2;
            chk("st_req",   32'(dmem_req_o), 32'd1);
            chk("st_we",    32'(dmem_we_o), 32'd1);
            chk("st_addr",  dmem_addr_o, {addr[31:2], 2'b00});
            chk("st_be",    32'(dmem_be_o), 32'(exp_be));
            chk("st_wdata", dmem_wdata_o, exp_wd);
            chk("st_stall", 32'(stall_o), 32'd1);
            step();
        end
        dmem_gnt_i = 1'b0;
        #2;
        chk("st_done_stall",  32'(stall_o), 32'd0);
        chk("st_done_pcwe",   32'(pc_we_o), 32'd1);
        chk("st_done_pcnext", pc_next_o, 32'h3004);
        chk("st_done_rfwe",   32'(rf_we_o), 32'd0);
        chk("st_done_req",    32'(dmem_req_o), 32'd0);
        step();
        #2;
        chk("st_after_pcwe", 32'(pc_we_o), 32'd0);
    endtask

    initial begin
        // valid,mem,we,size,addr,rd,rw,alu,jalr,pc4,br,pcb | rfwe,wdata,pcwe,pcnext,stall,mis
        vt[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0,   5'd5, 1'b1, 32'h1234, 1'b0, 32'h104, 1'b0, 32'h0,
                  1'b1, 32'h1234, 1'b1, 32'h104, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0,   5'd0, 1'b1, 32'h55,   1'b0, 32'h108, 1'b0, 32'h0,
                  1'b0, 32'h0,    1'b1, 32'h108, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0,   5'd1, 1'b1, 32'h500,  1'b1, 32'h208, 1'b1, 32'h500,
                  1'b1, 32'h208,  1'b1, 32'h500, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0,   5'd7, 1'b0, 32'h77,   1'b0, 32'h20C, 1'b1, 32'h300,
                  1'b0, 32'h0,    1'b1, 32'h300, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,   5'd9, 1'b1, 32'h99,   1'b0, 32'h210, 1'b0, 32'h0,
                  1'b0, 32'h0,    1'b0, 32'h210, 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h101, 5'd4, 1'b1, 32'h0,    1'b0, 32'h114, 1'b0, 32'h0,
                  1'b0, 32'h0,    1'b1, 32'h114, 1'b0, 1'b1};
        vt[6] = '{1'b1, 1'b1, 1'b0, 2'd1, 32'h103, 5'd4, 1'b1, 32'h0,    1'b0, 32'h118, 1'b0, 32'h0,
                  1'b0, 32'h0,    1'b1, 32'h118, 1'b0, 1'b1};
        vt[7] = '{1'b1, 1'b1, 1'b1, 2'd2, 32'h102, 5'd0, 1'b0, 32'h0,    1'b0, 32'h11C, 1'b1, 32'h400,
                  1'b0, 32'h0,    1'b1, 32'h400, 1'b0, 1'b1};
        vt[8] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h102, 5'd0, 1'b0, 32'h0,    1'b0, 32'h120, 1'b0, 32'h0,
                  1'b0, 32'h0,    1'b0, 32'h120, 1'b0, 1'b0};

        clr_inputs();
        rst_n = 1'b0;
        // Live ALU instruction during reset: outputs must still read zero.
        instr_valid_i = 1'b1;
        reg_write_i   = 1'b1;
        rd_i          = 5'd3;
        alu_data_i    = 32'hCAFE;
        pc_add4_i     = 32'h44;
        #3;
        chk("rst_rfwe",   32'(rf_we_o), 32'd0);
        chk("rst_pcwe",   32'(pc_we_o), 32'd0);
        chk("rst_pcnext", pc_next_o, 32'd0);
        chk("rst_waddr",  32'(rf_waddr_o), 32'd0);
        chk("rst_stall",  32'(stall_o), 32'd0);
        chk("rst_req",    32'(dmem_req_o), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        clr_inputs();

        // Single-cycle IDLE behaviour
        foreach (vt[k]) begin
            step();
            clr_inputs();
            instr_valid_i  = vt[k].valid;
            mem_op_i       = vt[k].mem_op;
            mem_we_i       = vt[k].we;
            size_i         = vt[k].size;
            addr_i         = vt[k].addr;
            rd_i           = vt[k].rd;
            reg_write_i    = vt[k].reg_write;
            alu_data_i     = vt[k].alu;
            setJalr_i      = vt[k].jalr;
            pc_add4_i      = vt[k].pc4;
            branch_taken_i = vt[k].br;
            pc_branch_i    = vt[k].pcb;
            #2;
            chk($sformatf("v%0d_rfwe", k),   32'(rf_we_o),    32'(vt[k].e_rfwe));
            chk($sformatf("v%0d_pcwe", k),   32'(pc_we_o),    32'(vt[k].e_pcwe));
            chk($sformatf("v%0d_pcnext", k), pc_next_o,       vt[k].e_pcnext);
            chk($sformatf("v%0d_stall", k),  32'(stall_o),    32'(vt[k].e_stall));
            chk($sformatf("v%0d_mis", k),    32'(misalign_o), 32'(vt[k].e_mis));
            chk($sformatf("v%0d_req", k),    32'(dmem_req_o), 32'd0);
            if (vt[k].e_rfwe) begin
                chk($sformatf("v%0d_waddr", k), 32'(rf_waddr_o), 32'(vt[k].rd));
                chk($sformatf("v%0d_wdata", k), rf_wdata_o,      vt[k].e_wdata);
            end
        end

        // Loads
        do_load(32'h103, 2'd0, 1'b0, 5'd3,  32'h80FFFFFF, 0, 32'hFFFFFF80);
        do_load(32'h101, 2'd0, 1'b1, 5'd8,  32'h12348056, 1, 32'h00000080);
        do_load(32'h102, 2'd1, 1'b0, 5'd9,  32'h80010000, 0, 32'hFFFF8001);
        do_load(32'h000, 2'd1, 1'b1, 5'd10, 32'hFFFF9ABC, 0, 32'h00009ABC);
        do_load(32'h204, 2'd2, 1'b0, 5'd11, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        do_load(32'h208, 2'd2, 1'b0, 5'd0,  32'h13579BDF, 2, 32'h0);

        // Stores
        do_store(32'h102, 2'd1, 32'h0000ABCD, 3, 4'b1100, 32'hABCDABCD);
        do_store(32'h101, 2'd0, 32'h1234565A, 0, 4'b0010, 32'h5A5A5A5A);
        do_store(32'h200, 2'd2, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D);

        // Reset asserted while waiting for read data
        step();
        clr_inputs();
        instr_valid_i = 1'b1;
        mem_op_i      = 1'b1;
        size_i        = 2'd2;
        addr_i        = 32'h300;
        rd_i          = 5'd6;
        reg_write_i   = 1'b1;
        pc_add4_i     = 32'h500;
        step();
        clr_inputs();
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        #2;
        chk("ab_wait_stall", 32'(stall_o), 32'd1);
        rst_n         = 1'b0;
        instr_valid_i = 1'b1;
        reg_write_i   = 1'b1;
        rd_i          = 5'd2;
        alu_data_i    = 32'h77;
        #1;
        chk("ab_rst_stall", 32'(stall_o), 32'd0);
        chk("ab_rst_pcwe",  32'(pc_we_o), 32'd0);
        chk("ab_rst_rfwe",  32'(rf_we_o), 32'd0);
        chk("ab_rst_req",   32'(dmem_req_o), 32'd0);
        step();
        rst_n = 1'b1;
        clr_inputs();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h11111111;
        #2;
        chk("ab_late_stall", 32'(stall_o), 32'd0);
        chk("ab_late_rfwe",  32'(rf_we_o), 32'd0);
        chk("ab_late_pcwe",  32'(pc_we_o), 32'd0);
        step();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        #2;
        chk("ab_next_rfwe", 32'(rf_we_o), 32'd0);
        chk("ab_next_pcwe", 32'(pc_we_o), 32'd0);
        step();
        instr_valid_i = 1'b1;
        reg_write_i   = 1'b1;
        rd_i          = 5'd12;
        alu_data_i    = 32'hBEEF;
        pc_add4_i     = 32'h604;
        #2;
        chk("ab_alu_rfwe",  32'(rf_we_o), 32'd1);
        chk("ab_alu_wdata", rf_wdata_o, 32'hBEEF);
        chk("ab_alu_stall", 32'(stall_o), 32'd0);
        step();
        clr_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
